// File: rtl/cpu_result_checker.sv
// Post-run result checker: releases the CPU under test for a fixed number of cycles,
// then scans every register and data-memory word, comparing observed against expected.
module cpu_result_checker #(
    parameter int N_REGISTERS   = 32,
    parameter int DATA_MEM_SIZE = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int RUN_CYCLES    = 27,
    parameter int CNT_WIDTH     = 8,
    localparam int TOTAL        = N_REGISTERS + DATA_MEM_SIZE,
    localparam int IDX_W        = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  cpu_run_o,
    output logic [IDX_W-1:0]      chk_idx_o,
    output logic                  chk_sel_o,
    output logic                  chk_valid_o,
    input  logic [DATA_WIDTH-1:0] dut_data_i,
    input  logic [DATA_WIDTH-1:0] exp_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  reg_ok_o,
    output logic                  mem_ok_o,
    output logic [CNT_WIDTH-1:0]  fail_count_o,
    output logic [IDX_W-1:0]      first_fail_idx_o,
    output logic                  first_fail_valid_o
);

    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   accept_s;

    logic                   cpu_run_q, chk_valid_q, busy_q, done_q;
    logic                   vld_d1_q;
    logic [IDX_W-1:0]       idx_d1_q;
    logic                   sel_d1_s;
    logic                   mismatch_s;

    logic [CNT_WIDTH-1:0]   fail_cnt_q, fail_cnt_d;
    logic [IDX_W-1:0]       ffi_q, ffi_d;
    logic                   ffv_q, ffv_d;
    logic                   reg_ok_q, reg_ok_d;
    logic                   mem_ok_q, mem_ok_d;
    logic                   pass_q;

    // Sequencer next-state: run countdown, then a gapless index sweep.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        idx_d     = idx_q;
        accept_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    run_cnt_d = RUN_W'(RUN_CYCLES - 1);
                    idx_d     = {IDX_W{1'b0}};
                    accept_s  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (run_cnt_q == {RUN_W{1'b0}}) begin
                    state_d = S_SCAN;
                end else begin
                    run_cnt_d = run_cnt_q - RUN_W'(1);
                end
            end
            S_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Compare stage works on the request issued one cycle earlier.
    assign sel_d1_s   = (32'(idx_d1_q) >= N_REGISTERS);
    assign mismatch_s = vld_d1_q && (dut_data_i != exp_data_i);

    // Result accumulation: cleared on acceptance, updated on each mismatching return.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        ffi_d      = ffi_q;
        ffv_d      = ffv_q;
        reg_ok_d   = reg_ok_q;
        mem_ok_d   = mem_ok_q;
        if (accept_s) begin
            fail_cnt_d = {CNT_WIDTH{1'b0}};
            ffv_d      = 1'b0;
            reg_ok_d   = 1'b1;
            mem_ok_d   = 1'b1;
        end else if (mismatch_s) begin
            if (fail_cnt_q != CNT_MAX) begin
                fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
            end else begin
                fail_cnt_d = fail_cnt_q;
            end
            if (sel_d1_s) begin
                mem_ok_d = 1'b0;
            end else begin
                reg_ok_d = 1'b0;
            end
            if (!ffv_q) begin
                ffi_d = idx_d1_q;
                ffv_d = 1'b1;
            end else begin
                ffi_d = ffi_q;
            end
        end else begin
            fail_cnt_d = fail_cnt_q;
        end
    end

    // State, pipeline and registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            run_cnt_q   <= {RUN_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            cpu_run_q   <= 1'b0;
            chk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_d1_q    <= 1'b0;
            idx_d1_q    <= {IDX_W{1'b0}};
            fail_cnt_q  <= {CNT_WIDTH{1'b0}};
            ffi_q       <= {IDX_W{1'b0}};
            ffv_q       <= 1'b0;
            reg_ok_q    <= 1'b1;
            mem_ok_q    <= 1'b1;
            pass_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            idx_q       <= idx_d;
            cpu_run_q   <= (state_d == S_RUN);
            chk_valid_q <= (state_d == S_SCAN);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_q == S_DONE);
            vld_d1_q    <= chk_valid_q;
            idx_d1_q    <= idx_q;
            fail_cnt_q  <= fail_cnt_d;
            ffi_q       <= ffi_d;
            ffv_q       <= ffv_d;
            reg_ok_q    <= reg_ok_d;
            mem_ok_q    <= mem_ok_d;
            pass_q      <= (fail_cnt_d == {CNT_WIDTH{1'b0}});
        end
    end

    assign cpu_run_o          = cpu_run_q;
    assign chk_idx_o          = idx_q;
    assign chk_sel_o          = (32'(idx_q) >= N_REGISTERS);
    assign chk_valid_o        = chk_valid_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign pass_o             = pass_q;
    assign reg_ok_o           = reg_ok_q;
    assign mem_ok_o           = mem_ok_q;
    assign fail_count_o       = fail_cnt_q;
    assign first_fail_idx_o   = ffi_q;
    assign first_fail_valid_o = ffv_q;

endmodule

// File: tb/tb_cpu_result_checker.sv
// Scoreboard bench for cpu_result_checker with 4 registers, 4 memory words, 3 run cycles.
module tb_cpu_result_checker;

    localparam int NR  = 4;
    localparam int NM  = 4;
    localparam int DW  = 32;
    localparam int RC  = 3;
    localparam int CW  = 2;
    localparam int TOT = NR + NM;
    localparam int IW  = 3;
    localparam int DONE_K = RC + TOT + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          cpu_run, chk_sel, chk_valid, busy, done, pass, reg_ok, mem_ok, ffv;
    logic [IW-1:0] chk_idx, ffi;
    logic [CW-1:0] fail_count;
    logic [DW-1:0] dut_data = '0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] dut_arr [TOT];
    logic [DW-1:0] exp_arr [TOT];

    typedef struct {
        logic [CW-1:0] fc;
        logic [IW-1:0] ffi;
        logic          ffv;
        logic          rok;
        logic          mok;
        logic          pas;
    } res_t;

    res_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    cpu_result_checker #(
        .N_REGISTERS(NR), .DATA_MEM_SIZE(NM), .DATA_WIDTH(DW),
        .RUN_CYCLES(RC), .CNT_WIDTH(CW)
    ) dut (
        .clock_i(clk), .reset_i(reset), .start_i(start),
        .cpu_run_o(cpu_run), .chk_idx_o(chk_idx), .chk_sel_o(chk_sel),
        .chk_valid_o(chk_valid), .dut_data_i(dut_data), .exp_data_i(exp_data),
        .busy_o(busy), .done_o(done), .pass_o(pass), .reg_ok_o(reg_ok),
        .mem_ok_o(mem_ok), .fail_count_o(fail_count),
        .first_fail_idx_o(ffi), .first_fail_valid_o(ffv)
    );

    always #5 clk = ~clk;

    // Memory/register responder: returns the data for last cycle's request.
    always @(posedge clk) begin
        dut_data <= dut_arr[chk_idx];
        exp_data <= exp_arr[chk_idx];
    end

    task automatic load_arrays(input logic [TOT-1:0] mask);
        for (int i = 0; i < TOT; i++) begin
            exp_arr[i] = $urandom;
            dut_arr[i] = mask[i] ? (exp_arr[i] ^ (32'd1 << $urandom_range(31, 0))) : exp_arr[i];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({cpu_run, chk_valid, chk_idx, busy, done, fail_count, ffi, ffv, reg_ok, mem_ok, pass} !== 16'h0007) begin
            err_cnt++;
            $display("FAIL reset_values: got %h want %h",
                     {cpu_run, chk_valid, chk_idx, busy, done, fail_count, ffi, ffv, reg_ok, mem_ok, pass}, 16'h0007);
        end
        reset = 1'b0;
    endtask

    // One full test: model expectation pushed at start, popped on the done pulse.
    task automatic run_test(input string name, input logic [TOT-1:0] mask, input logic repulse);
        res_t e;
        res_t got;
        int   n;
        bit   seen_done;
        load_arrays(mask);
        n = 0;
        e.ffv = 1'b0;
        e.ffi = 3'd0;
        for (int i = 0; i < TOT; i++) begin
            if (mask[i]) begin
                n++;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffi = IW'(i);
                end
            end
        end
        e.fc  = (n > 3) ? 2'd3 : CW'(n);
        e.rok = (mask[NR-1:0] == 4'd0);
        e.mok = (mask[TOT-1:NR] == 4'd0);
        e.pas = (n == 0);
        sb_q.push_back(e);
        seen_done = 1'b0;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= DONE_K + 2; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (k == 0) begin
                vec_cnt++;
                if ({fail_count, ffv, reg_ok, mem_ok} !== 5'b00011) begin
                    err_cnt++;
                    $display("FAIL %s accept_clear: got %b want 00011", name, {fail_count, ffv, reg_ok, mem_ok});
                end
            end
            vec_cnt++;
            if (cpu_run !== (k < RC)) begin
                err_cnt++;
                $display("FAIL %s cpu_run k=%0d: got %b want %b", name, k, cpu_run, (k < RC));
            end
            vec_cnt++;
            if (chk_valid !== (k >= RC && k < RC + TOT)) begin
                err_cnt++;
                $display("FAIL %s chk_valid k=%0d: got %b want %b", name, k, chk_valid, (k >= RC && k < RC + TOT));
            end
            if (k >= RC && k < RC + TOT) begin
                vec_cnt++;
                if (chk_idx !== IW'(k - RC) || chk_sel !== ((k - RC) >= NR)) begin
                    err_cnt++;
                    $display("FAIL %s chk_idx k=%0d: got %0d/%b want %0d/%b", name, k, chk_idx, chk_sel,
                             k - RC, ((k - RC) >= NR));
                end
            end
            vec_cnt++;
            if (busy !== (k < DONE_K)) begin
                err_cnt++;
                $display("FAIL %s busy k=%0d: got %b want %b", name, k, busy, (k < DONE_K));
            end
            vec_cnt++;
            if (done !== (k == DONE_K)) begin
                err_cnt++;
                $display("FAIL %s done k=%0d: got %b want %b", name, k, done, (k == DONE_K));
            end
            if (done && !seen_done) begin
                seen_done = 1'b1;
                if (sb_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL %s scoreboard_empty: got done with no expectation", name);
                end else begin
                    e = sb_q.pop_front();
                    got.fc = fail_count; got.ffi = ffi; got.ffv = ffv;
                    got.rok = reg_ok; got.mok = mem_ok; got.pas = pass;
                    vec_cnt++;
                    if (got.fc !== e.fc || got.ffv !== e.ffv || (e.ffv && got.ffi !== e.ffi) ||
                        got.rok !== e.rok || got.mok !== e.mok || got.pas !== e.pas) begin
                        err_cnt++;
                        $display("FAIL %s results: got fc=%0d ffi=%0d ffv=%b rok=%b mok=%b pass=%b want fc=%0d ffi=%0d ffv=%b rok=%b mok=%b pass=%b",
                                 name, got.fc, got.ffi, got.ffv, got.rok, got.mok, got.pas,
                                 e.fc, e.ffi, e.ffv, e.rok, e.mok, e.pas);
                    end
                end
            end
            if (k == DONE_K + 2) begin
                vec_cnt++;
                if (fail_count !== e.fc || pass !== e.pas || reg_ok !== e.rok || mem_ok !== e.mok) begin
                    err_cnt++;
                    $display("FAIL %s hold: got fc=%0d pass=%b rok=%b mok=%b want fc=%0d pass=%b rok=%b mok=%b",
                             name, fail_count, pass, reg_ok, mem_ok, e.fc, e.pas, e.rok, e.mok);
                end
            end
            if (repulse && (k == 1 || k == RC + 2)) begin
                start = 1'b1;
            end
        end
        if (!seen_done) begin
            err_cnt++;
            $display("FAIL %s done_timeout: got no done within %0d cycles want done at %0d", name, DONE_K + 2, DONE_K);
            sb_q.delete();
        end
    endtask

    task automatic test_reset_mid_scan();
        load_arrays(8'h00);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (RC + 1) begin
            @(posedge clk);
            #1;
        end
        vec_cnt++;
        if (chk_valid !== 1'b1 || chk_idx !== 3'd1) begin
            err_cnt++;
            $display("FAIL mid_scan_position: got valid=%b idx=%0d want valid=1 idx=1", chk_valid, chk_idx);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({cpu_run, chk_valid, chk_idx, busy, done, fail_count, ffi, ffv, reg_ok, mem_ok, pass} !== 16'h0007) begin
            err_cnt++;
            $display("FAIL mid_scan_reset_values: got %h want %h",
                     {cpu_run, chk_valid, chk_idx, busy, done, fail_count, ffi, ffv, reg_ok, mem_ok, pass}, 16'h0007);
        end
        reset = 1'b0;
        run_test("after_reset", 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        run_test("clean", 8'h00, 1'b0);
        run_test("mismatch_2_5", 8'b0010_0100, 1'b0);
        run_test("saturate_all", 8'hFF, 1'b0);
        run_test("mem_only_7", 8'b1000_0000, 1'b0);
        run_test("restart_ignored", 8'b0000_1000, 1'b1);
        test_reset_mid_scan();
        run_test("b2b_first_6", 8'b0100_0000, 1'b0);
        run_test("b2b_second_clean", 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
